// File: rtl/lsu_stage.sv
// Memory stage after the ALU: issues one data-memory access per op over a
// req/gnt/rvalid port, aligns/extends load data and holds one writeback record.
module lsu_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_store_dat,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [4:0]      in_rd,
  output logic            dmem_req,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t state, state_nxt;

  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic            ld_q;

  logic            accept, is_mem, width_ok, misal, bad, go_mem;
  logic [1:0]      off;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata, shifted, ld_data;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign off      = in_alu_out[1:0];
  assign is_mem   = in_is_load || in_is_store;

  always_comb begin
    width_ok = 1'b0;
    if (in_is_load)
      width_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                 (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    else
      width_ok = (in_funct3[2] == 1'b0) && (in_funct3[1:0] != 2'b11);
    misal  = ((in_funct3[1:0] == 2'b01) && off[0]) ||
             ((in_funct3[1:0] == 2'b10) && (off != 2'b00));
    bad    = is_mem && (!width_ok || misal);
    go_mem = is_mem && !bad;
  end

  // Store lanes: data replicated across the word, enables pick the lanes.
  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    if (in_is_store) begin
      case (in_funct3[1:0])
        2'b00:   begin be = 4'(4'b0001 << off); wdata = {4{in_store_dat[7:0]}};  end
        2'b01:   begin be = 4'(4'b0011 << off); wdata = {2{in_store_dat[15:0]}}; end
        default: begin be = 4'b1111;            wdata = in_store_dat;            end
      endcase
    end
  end

  always_comb begin
    shifted = dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'b0, shifted[7:0]};
      3'b101:  ld_data = {16'b0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)      state_nxt = go_mem ? REQ : OUT;
      REQ:  if (dmem_gnt)    state_nxt = ld_q ? WAIT : OUT;
      WAIT: if (dmem_rvalid) state_nxt = OUT;
      OUT:  if (wb_ready)    state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q      <= '0;
      f3_q       <= '0;
      ld_q       <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          off_q    <= off;
          f3_q     <= in_funct3;
          ld_q     <= in_is_load;
          wb_rd    <= in_rd;
          wb_err   <= bad;
          wb_data  <= in_alu_out;   // ALU result, or faulting address on error
          wb_we    <= !is_mem && (in_rd != 5'd0);
          wb_valid <= !go_mem;
          if (go_mem) begin
            dmem_req   <= 1'b1;
            dmem_addr  <= {in_alu_out[XLEN-1:2], 2'b00};
            dmem_be    <= be;
            dmem_wdata <= wdata;
          end
        end
        REQ: if (dmem_gnt) begin
          dmem_req <= 1'b0;
          if (!ld_q) wb_valid <= 1'b1;
        end
        WAIT: if (dmem_rvalid) begin
          wb_data  <= ld_data;
          wb_we    <= (wb_rd != 5'd0);
          wb_valid <= 1'b1;
        end
        OUT: if (wb_ready) wb_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: a spec-level model predicts each memory request
// and writeback record; a negedge monitor compares them, plus literal pins.
module tb_lsu_stage;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_alu_out = '0, in_store_dat = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_is_load = 1'b0, in_is_store = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        dmem_req;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_ready = 1'b0, wb_we, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  lsu_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_out(in_alu_out), .in_store_dat(in_store_dat), .in_funct3(in_funct3),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_rd(in_rd),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        last;
  int          total = 0, bad = 0, cyc = 0, req_seen = 0;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, req);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_err(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (!ld && !st) return 0;
    legal = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    return !legal || ((a % size_of(f3)) != 0);
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    longint unsigned v, mask;
    int s;
    s    = size_of(f3);
    v    = longint'(rdata) >> (8 * (a % 4));
    mask = (64'd1 << (8 * s)) - 1;
    v    = v & mask;
    if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Monitor: request fields whenever a request is up, records on handshake.
  always @(negedge clk) if (rst_n) begin
    if (dmem_req) begin
      req_seen++;
      chk("req_addr", dmem_addr, exp_addr);
      chk("req_be", {28'b0, dmem_be}, {28'b0, exp_be});
      chk("req_wdata", dmem_wdata, exp_wdata);
    end
    if (wb_valid) chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
    if (wb_valid && wb_ready) begin
      if (exp_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        last = exp_q.pop_front();
        chk("wb_we", {31'b0, wb_we}, {31'b0, last.we});
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, last.rd});
        chk("wb_data", wb_data, last.data);
        chk("wb_err", {31'b0, wb_err}, {31'b0, last.err});
      end
    end
  end

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd, input int gd, input int rv,
                        input logic [31:0] rdata, input int hold, output int lat);
    rec_t r;
    bit   err, mem;
    int   acc, n, sb;
    err = is_err(ld, st, f3, a);
    mem = (ld || st) && !err;
    exp_addr  = {a[31:2], 2'b00};
    exp_be    = 4'b0000;
    exp_wdata = '0;
    if (st) begin
      exp_be = 4'((1 << size_of(f3)) - 1) << (a % 4);
      for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = sd[8*(i % size_of(f3)) +: 8];
    end
    r.err  = err;
    r.rd   = rd;
    r.data = (ld && !err) ? load_val(f3, a, rdata) : a;
    r.we   = !err && !st && (rd != 0);
    exp_q.push_back(r);
    sb = req_seen;
    in_valid = 1'b1; in_alu_out = a; in_store_dat = sd; in_funct3 = f3;
    in_is_load = ld; in_is_store = st; in_rd = rd;
    @(posedge clk); #1 in_valid = 1'b0;
    acc = cyc;
    if (mem) begin
      chk("req_up", {31'b0, dmem_req}, 32'd1);
      repeat (gd) @(posedge clk);
      #1 dmem_gnt = 1'b1;
      @(posedge clk); #1 dmem_gnt = 1'b0;
      chk("req_down", {31'b0, dmem_req}, 32'd0);
      if (ld) begin
        repeat (rv) @(posedge clk);
        #1 dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(posedge clk); #1 dmem_rvalid = 1'b0; dmem_rdata = '0;
      end
    end
    n = 0;
    while (!wb_valid && n < 50) begin @(posedge clk); #1 n++; end
    chk("wb_timeout", {31'b0, wb_valid}, 32'd1);
    lat = cyc - acc + 1;
    if (!mem) chk("no_req", req_seen - sb, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, wb_valid}, 32'd1);
      chk("hold_data", wb_data, r.data);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
    end
    #1 wb_ready = 1'b1;
    @(posedge clk); #1 wb_ready = 1'b0;
    chk("wb_drop", {31'b0, wb_valid}, 32'd0);
  endtask

  int lat;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_outs", {dmem_req, dmem_be, wb_valid, wb_we, wb_err, wb_rd}, 32'd0);
    chk("rst_buses", dmem_addr | dmem_wdata | wb_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 3'b000, 32'h1234, 0, 5, 0, 0, 0, 0, lat);
    chk("add_lat", lat, 1);
    chk("add_data", last.data, 32'h1234);
    run_op(0, 0, 3'b000, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, lat);
    chk("alu_rd0_we", {31'b0, last.we}, 32'd0);

    run_op(0, 1, 3'b000, 32'h103, 32'hAB, 3, 2, 0, 0, 0, lat);
    chk("sb_lat", lat, 4);
    chk("sb_be", {28'b0, exp_be}, 32'b1000);
    chk("sb_wdata", exp_wdata, 32'hABABABAB);
    run_op(0, 1, 3'b001, 32'h102, 32'h1234CAFE, 3, 0, 0, 0, 0, lat);
    chk("sh_wdata", exp_wdata, 32'hCAFECAFE);
    run_op(0, 1, 3'b010, 32'h200, 32'h11223344, 4, 1, 0, 0, 0, lat);

    run_op(1, 0, 3'b000, 32'h102, 0, 7, 0, 0, 32'h0080FF00, 0, lat);
    chk("lb_lat", lat, 3);
    chk("lb_data", last.data, 32'hFFFFFF80);
    run_op(1, 0, 3'b100, 32'h102, 0, 7, 0, 0, 32'h0080FF00, 0, lat);
    chk("lbu_data", last.data, 32'h80);
    run_op(1, 0, 3'b101, 32'h102, 0, 8, 1, 1, 32'h8001_0000, 0, lat);
    chk("lhu_data", last.data, 32'h8001);
    run_op(1, 0, 3'b001, 32'h100, 0, 0, 0, 0, 32'h8001, 3, lat);
    chk("lh_data", last.data, 32'hFFFF8001);
    run_op(1, 0, 3'b010, 32'h204, 0, 9, 1, 2, 32'h12345678, 0, lat);
    chk("lw_lat", lat, 6);

    run_op(1, 0, 3'b010, 32'h102, 0, 6, 0, 0, 0, 0, lat);
    chk("lw_mis_err", {31'b0, last.err}, 32'd1);
    chk("lw_mis_data", last.data, 32'h102);
    run_op(1, 0, 3'b011, 32'h100, 0, 6, 0, 0, 0, 0, lat);
    run_op(0, 1, 3'b100, 32'h100, 32'h55, 6, 0, 0, 0, 0, lat);
    run_op(0, 1, 3'b001, 32'h101, 32'h55, 6, 0, 0, 0, 0, lat);

    // Reset while waiting for load data; the late response must be ignored.
    exp_addr = 32'h200; exp_be = 4'b0000; exp_wdata = '0;
    in_valid = 1'b1; in_alu_out = 32'h200; in_funct3 = 3'b010;
    in_is_load = 1'b1; in_is_store = 1'b0; in_rd = 4;
    @(posedge clk); #1 in_valid = 1'b0; dmem_gnt = 1'b1;
    @(posedge clk); #1 dmem_gnt = 1'b0;
    chk("wait_no_req", {31'b0, dmem_req}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1 dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_outs", {dmem_req, dmem_be, wb_valid, wb_we, wb_err, wb_rd}, 32'd0);
      chk("rstmid_buses", dmem_addr | dmem_wdata | wb_data, 32'd0);
      chk("rstmid_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
